// File: rtl/normalizer_round_pipe.sv
// Two-stage normaliser and round-to-nearest-even unit between the mantissa adder and the
// result packer. S1 normalises with a leading-zero count, S2 rounds and raises status flags.
module normalizer_round_pipe #(
   parameter int EXP_WIDTH      = 8,
   parameter int MANTISSA_WIDTH = 23
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic                        valid_in,
   output logic                        ready_out,
   input  logic                        sign_in,
   input  logic [EXP_WIDTH-1:0]        expoent_in,
   input  logic [MANTISSA_WIDTH+1:0]   result_in,
   input  logic [2:0]                  grs_in,
   output logic                        valid_out,
   input  logic                        ready_in,
   output logic                        sign_out,
   output logic [EXP_WIDTH-1:0]        normal_e_out,
   output logic [MANTISSA_WIDTH:0]     normal_m_out,
   output logic                        overflow_out,
   output logic                        underflow_out,
   output logic                        inexact_out,
   output logic                        zero_out
);

   localparam int M   = MANTISSA_WIDTH;
   localparam int E   = EXP_WIDTH;
   localparam int LZW = $clog2(M + 2);
   localparam logic [E:0] EXP_MAX = {1'b0, {E{1'b1}}};

   // Stage 1 registers
   logic          r_s1_valid, r_s1_sign, r_s1_g, r_s1_r, r_s1_s;
   logic          r_s1_special, r_s1_flush, r_s1_zero;
   logic [E:0]    r_s1_exp;
   logic [M:0]    r_s1_mant;

   // Stage 2 registers (drive the outputs directly)
   logic          r_s2_valid, r_s2_sign, r_s2_ovf, r_s2_unf, r_s2_inx, r_s2_zero;
   logic [E-1:0]  r_s2_exp;
   logic [M:0]    r_s2_mant;

   logic          w_s2_load;
   logic [LZW-1:0] w_lz;
   logic [M+2:0]  w_ext, w_shifted;
   logic [E:0]    w_exp_diff;
   logic          w_underflow;

   logic          w_s1_g, w_s1_r, w_s1_s, w_s1_special, w_s1_flush, w_s1_zero;
   logic [E:0]    w_s1_exp;
   logic [M:0]    w_s1_mant;

   logic          w_round_up;
   logic [M+1:0]  w_mant_sum;
   logic [E:0]    w_s2_exp_full;
   logic [M:0]    w_s2_mant;
   logic          w_s2_ovf, w_s2_unf, w_s2_inx, w_s2_zero;

   assign w_s2_load = !r_s2_valid || ready_in;
   assign ready_out = !r_s1_valid || w_s2_load;

   // Highest set bit wins; an all-zero result leaves the guard bit as the leading one.
   always_comb begin
      w_lz = LZW'(M + 1);
      for (int i = 0; i <= M; i++) begin
         if (result_in[i]) w_lz = LZW'(M - i);
      end
   end

   assign w_ext       = {result_in[M:0], grs_in[2], grs_in[1]};
   assign w_shifted   = w_ext << w_lz;
   assign w_exp_diff  = {1'b0, expoent_in} - (E+1)'(w_lz);
   assign w_underflow = w_exp_diff[E] || (w_exp_diff == '0);

   always_comb begin
      w_s1_exp     = '0;
      w_s1_mant    = '0;
      w_s1_g       = 1'b0;
      w_s1_r       = 1'b0;
      w_s1_s       = 1'b0;
      w_s1_special = 1'b0;
      w_s1_flush   = 1'b0;
      w_s1_zero    = 1'b0;
      if (&expoent_in) begin
         w_s1_special = 1'b1;
         w_s1_exp     = {1'b0, expoent_in};
         w_s1_mant    = result_in[M:0];
      end else if (result_in == '0 && grs_in == 3'b000) begin
         w_s1_zero = 1'b1;
      end else if (result_in[M+1]) begin
         w_s1_mant = result_in[M+1:1];
         w_s1_g    = result_in[0];
         w_s1_r    = grs_in[2];
         w_s1_s    = grs_in[1] | grs_in[0];
         w_s1_exp  = {1'b0, expoent_in} + (E+1)'(1);
      end else if (w_underflow) begin
         w_s1_flush = 1'b1;
         w_s1_zero  = 1'b1;
      end else begin
         w_s1_mant = w_shifted[M+2:2];
         w_s1_g    = w_shifted[1];
         w_s1_r    = w_shifted[0];
         w_s1_s    = grs_in[0];
         w_s1_exp  = w_exp_diff;
      end
   end

   assign w_round_up = r_s1_g & (r_s1_r | r_s1_s | r_s1_mant[0]);
   assign w_mant_sum = {1'b0, r_s1_mant} + (M+2)'(w_round_up);

   always_comb begin
      w_s2_exp_full = '0;
      w_s2_mant     = '0;
      w_s2_ovf      = 1'b0;
      w_s2_unf      = 1'b0;
      w_s2_inx      = 1'b0;
      w_s2_zero     = 1'b0;
      if (r_s1_special) begin
         w_s2_exp_full = r_s1_exp;
         w_s2_mant     = r_s1_mant;
      end else if (r_s1_zero) begin
         w_s2_zero = 1'b1;
         w_s2_unf  = r_s1_flush;
         w_s2_inx  = r_s1_flush;
      end else begin
         if (w_mant_sum[M+1]) begin
            w_s2_mant     = {1'b1, {M{1'b0}}};
            w_s2_exp_full = r_s1_exp + (E+1)'(1);
         end else begin
            w_s2_mant     = w_mant_sum[M:0];
            w_s2_exp_full = r_s1_exp;
         end
         w_s2_inx = r_s1_g | r_s1_r | r_s1_s;
         // Exponent is one bit wider than the field, so a rounding carry past all-ones is still seen.
         if (w_s2_exp_full >= EXP_MAX) begin
            w_s2_exp_full = EXP_MAX;
            w_s2_mant     = '0;
            w_s2_ovf      = 1'b1;
            w_s2_inx      = 1'b1;
         end
      end
   end

   // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_s1_valid   <= 1'b0;
         r_s1_sign    <= 1'b0;
         r_s1_exp     <= '0;
         r_s1_mant    <= '0;
         r_s1_g       <= 1'b0;
         r_s1_r       <= 1'b0;
         r_s1_s       <= 1'b0;
         r_s1_special <= 1'b0;
         r_s1_flush   <= 1'b0;
         r_s1_zero    <= 1'b0;
         r_s2_valid   <= 1'b0;
         r_s2_sign    <= 1'b0;
         r_s2_exp     <= '0;
         r_s2_mant    <= '0;
         r_s2_ovf     <= 1'b0;
         r_s2_unf     <= 1'b0;
         r_s2_inx     <= 1'b0;
         r_s2_zero    <= 1'b0;
      end else begin
         if (ready_out) begin
            r_s1_valid <= valid_in;
            if (valid_in) begin
               r_s1_sign    <= sign_in;
               r_s1_exp     <= w_s1_exp;
               r_s1_mant    <= w_s1_mant;
               r_s1_g       <= w_s1_g;
               r_s1_r       <= w_s1_r;
               r_s1_s       <= w_s1_s;
               r_s1_special <= w_s1_special;
               r_s1_flush   <= w_s1_flush;
               r_s1_zero    <= w_s1_zero;
            end
         end
         if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_s2_sign <= r_s1_sign;
               r_s2_exp  <= w_s2_exp_full[E-1:0];
               r_s2_mant <= w_s2_mant;
               r_s2_ovf  <= w_s2_ovf;
               r_s2_unf  <= w_s2_unf;
               r_s2_inx  <= w_s2_inx;
               r_s2_zero <= w_s2_zero;
            end
         end
      end
   end

   assign valid_out     = r_s2_valid;
   assign sign_out      = r_s2_sign;
   assign normal_e_out  = r_s2_exp;
   assign normal_m_out  = r_s2_mant;
   assign overflow_out  = r_s2_ovf;
   assign underflow_out = r_s2_unf;
   assign inexact_out   = r_s2_inx;
   assign zero_out      = r_s2_zero;

endmodule

// File: tb/tb_normalizer_round_pipe.sv
// Directed bench for normalizer_round_pipe: single-item vectors with hand-computed results,
// then a backpressure run of four items and a reset pulse with items in flight.
module tb_normalizer_round_pipe;

   localparam int E = 8;
   localparam int M = 23;

   logic          clk_in = 1'b0;
   logic          rst_in, valid_in, ready_out, sign_in, valid_out, ready_in, sign_out;
   logic [E-1:0]  expoent_in, normal_e_out;
   logic [M+1:0]  result_in;
   logic [2:0]    grs_in;
   logic [M:0]    normal_m_out;
   logic          overflow_out, underflow_out, inexact_out, zero_out;

   int n_tests = 0;
   int n_fail  = 0;

   normalizer_round_pipe #(.EXP_WIDTH(E), .MANTISSA_WIDTH(M)) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .sign_in       (sign_in),
      .expoent_in    (expoent_in),
      .result_in     (result_in),
      .grs_in        (grs_in),
      .valid_out     (valid_out),
      .ready_in      (ready_in),
      .sign_out      (sign_out),
      .normal_e_out  (normal_e_out),
      .normal_m_out  (normal_m_out),
      .overflow_out  (overflow_out),
      .underflow_out (underflow_out),
      .inexact_out   (inexact_out),
      .zero_out      (zero_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_tests++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // One item in, checked two edges after acceptance; flags packed as {ovf, unf, inx, zero}.
   task automatic run_one(input string tag, input logic sgn, input logic [E-1:0] e,
                          input logic [M+1:0] res, input logic [2:0] grs,
                          input logic [E-1:0] exp_e, input logic [M:0] exp_m, input logic [3:0] exp_f);
      ready_in   = 1'b1;
      valid_in   = 1'b1;
      sign_in    = sgn;
      expoent_in = e;
      result_in  = res;
      grs_in     = grs;
      #1;
      check({tag, "_ready"}, 32'(ready_out), 32'd1);
      step();
      valid_in = 1'b0;
      check({tag, "_lat1_valid"}, 32'(valid_out), 32'd0);
      step();
      check({tag, "_valid"}, 32'(valid_out), 32'd1);
      check({tag, "_sign"}, 32'(sign_out), 32'(sgn));
      check({tag, "_exp"}, 32'(normal_e_out), 32'(exp_e));
      check({tag, "_mant"}, 32'(normal_m_out), 32'(exp_m));
      check({tag, "_flags"}, 32'({overflow_out, underflow_out, inexact_out, zero_out}), 32'(exp_f));
      step();
   endtask

   logic [E-1:0] bp_e_in [4];
   logic [M+1:0] bp_r_in [4];
   logic [2:0]   bp_g_in [4];
   logic [E-1:0] bp_e_ex [4];
   logic [M:0]   bp_m_ex [4];
   logic [3:0]   bp_f_ex [4];

   initial begin
      int  tx, rx, seen;
      logic acc;

      rst_in     = 1'b1;
      valid_in   = 1'b0;
      ready_in   = 1'b0;
      sign_in    = 1'b0;
      expoent_in = '0;
      result_in  = '0;
      grs_in     = '0;
      step();
      step();
      rst_in = 1'b0;
      #1;
      check("rst_valid", 32'(valid_out), 32'd0);
      check("rst_ready", 32'(ready_out), 32'd1);
      check("rst_data", 32'({sign_out, normal_e_out, normal_m_out}), 32'd0);
      check("rst_flags", 32'({overflow_out, underflow_out, inexact_out, zero_out}), 32'd0);

      run_one("carry",     1'b0, 8'h80, 25'h1800000, 3'b000, 8'h81, 24'hC00000, 4'b0000);
      run_one("lshift23",  1'b1, 8'h85, 25'h0000001, 3'b000, 8'h6E, 24'h800000, 4'b0000);
      run_one("lshift24",  1'b0, 8'h7F, 25'h0000000, 3'b100, 8'h67, 24'h800000, 4'b0000);
      run_one("tie_odd",   1'b0, 8'h7F, 25'h0800001, 3'b100, 8'h7F, 24'h800002, 4'b0010);
      run_one("tie_even",  1'b1, 8'h7F, 25'h0800000, 3'b100, 8'h7F, 24'h800000, 4'b0010);
      run_one("rnd_carry", 1'b0, 8'h7F, 25'h0FFFFFF, 3'b110, 8'h80, 24'h800000, 4'b0010);
      run_one("overflow",  1'b0, 8'hFE, 25'h1000000, 3'b000, 8'hFF, 24'h000000, 4'b1010);
      run_one("underflow", 1'b1, 8'h05, 25'h0000100, 3'b000, 8'h00, 24'h000000, 4'b0111);
      run_one("zero",      1'b0, 8'h40, 25'h0000000, 3'b000, 8'h00, 24'h000000, 4'b0001);
      run_one("special",   1'b1, 8'hFF, 25'h0C00000, 3'b101, 8'hFF, 24'hC00000, 4'b0000);
      run_one("sticky_up", 1'b0, 8'h10, 25'h0400000, 3'b011, 8'h0F, 24'h800001, 4'b0010);

      // Backpressure: ready_in low for the first five cycles of a four-item burst.
      bp_e_in[0] = 8'h80; bp_r_in[0] = 25'h1800000; bp_g_in[0] = 3'b000;
      bp_e_ex[0] = 8'h81; bp_m_ex[0] = 24'hC00000; bp_f_ex[0] = 4'b0000;
      bp_e_in[1] = 8'h85; bp_r_in[1] = 25'h0000001; bp_g_in[1] = 3'b000;
      bp_e_ex[1] = 8'h6E; bp_m_ex[1] = 24'h800000; bp_f_ex[1] = 4'b0000;
      bp_e_in[2] = 8'h7F; bp_r_in[2] = 25'h0800001; bp_g_in[2] = 3'b100;
      bp_e_ex[2] = 8'h7F; bp_m_ex[2] = 24'h800002; bp_f_ex[2] = 4'b0010;
      bp_e_in[3] = 8'h7F; bp_r_in[3] = 25'h0FFFFFF; bp_g_in[3] = 3'b110;
      bp_e_ex[3] = 8'h80; bp_m_ex[3] = 24'h800000; bp_f_ex[3] = 4'b0010;

      tx = 0;
      rx = 0;
      sign_in = 1'b0;
      for (int cyc = 0; cyc < 30 && rx < 4; cyc++) begin
         ready_in = (cyc >= 5);
         if (tx < 4) begin
            valid_in   = 1'b1;
            expoent_in = bp_e_in[tx];
            result_in  = bp_r_in[tx];
            grs_in     = bp_g_in[tx];
         end else begin
            valid_in = 1'b0;
         end
         #1;
         if (cyc == 2) check("bp_ready_drop", 32'(ready_out), 32'd0);
         if (valid_out && !ready_in) begin
            check("bp_hold_exp", 32'(normal_e_out), 32'(bp_e_ex[0]));
            check("bp_hold_mant", 32'(normal_m_out), 32'(bp_m_ex[0]));
         end
         if (valid_out && ready_in) begin
            check("bp_out_exp", 32'(normal_e_out), 32'(bp_e_ex[rx]));
            check("bp_out_mant", 32'(normal_m_out), 32'(bp_m_ex[rx]));
            check("bp_out_flags", 32'({overflow_out, underflow_out, inexact_out, zero_out}),
                  32'(bp_f_ex[rx]));
            rx++;
         end
         acc = valid_in && ready_out;
         @(posedge clk_in);
         #1;
         if (acc) tx++;
      end
      check("bp_delivered", 32'(rx), 32'd4);
      valid_in = 1'b0;
      step();
      check("bp_drained", 32'(valid_out), 32'd0);

      // Reset with two items in flight.
      ready_in   = 1'b1;
      valid_in   = 1'b1;
      expoent_in = 8'h80;
      result_in  = 25'h1800000;
      grs_in     = 3'b000;
      step();
      expoent_in = 8'h85;
      result_in  = 25'h0000001;
      step();
      valid_in = 1'b0;
      check("rst_inflight_pre", 32'(valid_out), 32'd1);
      rst_in = 1'b1;
      step();
      rst_in = 1'b0;
      check("rst_inflight_valid", 32'(valid_out), 32'd0);
      seen = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (valid_out) seen++;
      end
      check("rst_nothing_emitted", 32'(seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
